// File: rtl/hp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// hp_issue_ctrl
//
// Issue-side controller for the half-precision FPU datapath (hp_top).
// Takes one op request from the core, presents the latched operands and op code
// to the FPU, pulses fpu_ops_ready once, waits FPU_LATENCY cycles, captures the
// FPU result and class flags, and returns them on a response channel.
// Only one op is in flight at a time. Requests are never queued.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. A valid side holds its payload stable until that edge. The
// controller never makes req_ready depend on req_valid. It never makes
// rsp_valid depend on rsp_ready.
//
// Parameters
//   num_bits     operand/result width (16 = FP16, 32 = FP32)
//   FPU_LATENCY  cycles from the ops_ready cycle to a valid fpu_res (0..15)
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   req_valid/ready  request handshake; req_op/req_a/req_b are its payload
//   fpu_src_a/b      latched operands to the FPU
//   fpu_operation    latched op code to the FPU
//   fpu_ops_ready    one-cycle start pulse to the FPU
//   fpu_res/flags    FPU result and class flags {zero,inf,subN,Norm,QNan,SNan}
//   rsp_valid/ready  response handshake; rsp_data/rsp_flags are its payload
//   busy             high whenever the controller is not idle
//
// Optional feature: define FPU_STICKY_FLAGS_EN to add sticky_clr (in) and
// sticky_flags (out). sticky_flags accumulates the OR of all captured flags.
// -----------------------------------------------------------------------------
module hp_issue_ctrl #(
    parameter int num_bits    = 16,
    parameter int FPU_LATENCY = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [num_bits-1:0] req_a,
    input  logic [num_bits-1:0] req_b,
    output logic [num_bits-1:0] fpu_src_a,
    output logic [num_bits-1:0] fpu_src_b,
    output logic [2:0]          fpu_operation,
    output logic                fpu_ops_ready,
    input  logic [num_bits-1:0] fpu_res,
    input  logic [5:0]          fpu_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [num_bits-1:0] rsp_data,
    output logic [5:0]          rsp_flags,
`ifdef FPU_STICKY_FLAGS_EN
    input  logic                sticky_clr,
    output logic [5:0]          sticky_flags,
`endif
    output logic                busy
);

    // The down-counter is 4 bits wide, so latencies above 15 cannot be represented.
    if (FPU_LATENCY < 0 || FPU_LATENCY > 15) begin : g_bad_latency
        $fatal(1, "hp_issue_ctrl: FPU_LATENCY must be in 0..15");
    end

    localparam logic [3:0] LAT_INIT = 4'(FPU_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  first_q, first_d;   // marks the first EXEC cycle
    logic [num_bits-1:0]   a_q, a_d;
    logic [num_bits-1:0]   b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic [num_bits-1:0]   data_q, data_d;
    logic [5:0]            flags_q, flags_d;
    logic                  capture;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        flags_d = flags_q;
        capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // req_ready is high in IDLE whenever reset is low. While reset
                // is high the flops are held, so only req_valid gates the accept.
                if (req_valid) begin
                    state_d = ST_EXEC;
                    cnt_d   = LAT_INIT;
                    first_d = 1'b1;
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    // FPU output is valid this cycle. Sample it at this edge.
                    capture = 1'b1;
                    data_d  = fpu_res;
                    flags_d = fpu_flags;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'd0;
            data_q  <= '0;
            flags_q <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            flags_q <= flags_d;
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    logic [5:0] sticky_q, sticky_d;

    // When a clear and a capture happen on the same edge, the clear drops the
    // history, but the flags from that capture are still kept.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr && capture) begin
            sticky_d = fpu_flags;
        end else if (sticky_clr) begin
            sticky_d = 6'd0;
        end else if (capture) begin
            sticky_d = sticky_q | fpu_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 6'd0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    // capture only feeds the sticky register, which is absent in this build.
    logic unused_capture;
    assign unused_capture = capture;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready     = (state_q == ST_IDLE) & ~reset;
    assign busy          = (state_q != ST_IDLE);
    assign fpu_ops_ready = (state_q == ST_EXEC) & first_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign fpu_src_a     = a_q;
    assign fpu_src_b     = b_q;
    assign fpu_operation = op_q;
    assign rsp_data      = data_q;
    assign rsp_flags     = flags_q;

endmodule

// File: tb/tb_hp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hp_issue_ctrl
//
// Bench for hp_issue_ctrl built with FPU_LATENCY = 3.
//
// A stand-in FPU drives a deterministic result and flag pattern only in the
// cycle that is FPU_LATENCY cycles after the ops_ready pulse. In every other
// cycle it drives random noise. A capture on the wrong cycle therefore shows
// up as a wrong rsp_data or rsp_flags value.
//
// The reference model works per transaction. It records the cycle in which an
// op was accepted and derives every expected output from that cycle number
// plus the latency.
// -----------------------------------------------------------------------------
module tb_hp_issue_ctrl;

    localparam int LAT = 3;
    localparam int W   = 16;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [W-1:0]  fpu_src_a;
    logic [W-1:0]  fpu_src_b;
    logic [2:0]    fpu_operation;
    logic          fpu_ops_ready;
    logic [W-1:0]  fpu_res;
    logic [5:0]    fpu_flags;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic [5:0]    rsp_flags;
    logic          busy;
`ifdef FPU_STICKY_FLAGS_EN
    logic [5:0]    sticky_flags;
`endif

    hp_issue_ctrl #(
        .num_bits    (W),
        .FPU_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .fpu_src_a     (fpu_src_a),
        .fpu_src_b     (fpu_src_b),
        .fpu_operation (fpu_operation),
        .fpu_ops_ready (fpu_ops_ready),
        .fpu_res       (fpu_res),
        .fpu_flags     (fpu_flags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_flags     (rsp_flags),
`ifdef FPU_STICKY_FLAGS_EN
        .sticky_clr    (1'b0),
        .sticky_flags  (sticky_flags),
`endif
        .busy          (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stand-in FPU ----------------
    function automatic logic [W-1:0] fake_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
        return a ^ {b[7:0], b[15:8]} ^ {op, 13'h0A5};
    endfunction

    function automatic logic [5:0] fake_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
        return {op, a[2:0] ^ b[15:13]};
    endfunction

    int          fpu_age = 1000;
    logic [31:0] noise_q = 32'h0;
    int          fpu_k;

    always @(posedge clk) begin
        noise_q <= $urandom;
        if (fpu_ops_ready) fpu_age <= 1;
        else if (fpu_age < 1000) fpu_age <= fpu_age + 1;
    end

    always_comb begin
        fpu_k     = fpu_ops_ready ? 0 : fpu_age;
        fpu_res   = noise_q[15:0];
        fpu_flags = noise_q[21:16];
        if (fpu_k == LAT) begin
            fpu_res   = fake_res(fpu_src_a, fpu_src_b, fpu_operation);
            fpu_flags = fake_flags(fpu_src_a, fpu_src_b, fpu_operation);
        end
    end

    // ---------------- scoreboard / model state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    bit           in_flight = 1'b0;
    int           acc_cyc  = 0;
    logic [W-1:0] cur_a, cur_b;
    logic [2:0]   cur_op;
    logic [W-1:0] exp_q[$];
    logic [5:0]   expf_q[$];
    int           n_req = 0;
    int           n_rsp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = in_flight && (cyc >= acc_cyc + 1 + LAT);
        chk("busy",      32'(busy),          32'(in_flight));
        chk("req_ready", 32'(req_ready),     32'(!in_flight));
        chk("ops_ready", 32'(fpu_ops_ready), 32'(in_flight && cyc == acc_cyc));
        chk("rsp_valid", 32'(rsp_valid),     32'(ev));
        if (in_flight) begin
            chk("src_a",     32'(fpu_src_a),     32'(cur_a));
            chk("src_b",     32'(fpu_src_b),     32'(cur_b));
            chk("operation", 32'(fpu_operation), 32'(cur_op));
        end
        if (ev) begin
            chk("rsp_data",  32'(rsp_data),  32'(exp_q[0]));
            chk("rsp_flags", 32'(rsp_flags), 32'(expf_q[0]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      32'(busy),          0);
        chk({tag, "_req_ready"}, 32'(req_ready),     0);
        chk({tag, "_ops_ready"}, 32'(fpu_ops_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid),     0);
        chk({tag, "_src_a"},     32'(fpu_src_a),     0);
        chk({tag, "_src_b"},     32'(fpu_src_b),     0);
        chk({tag, "_operation"}, 32'(fpu_operation), 0);
        chk({tag, "_rsp_data"},  32'(rsp_data),      0);
        chk({tag, "_rsp_flags"}, 32'(rsp_flags),     0);
    endtask

    // Called at a falling edge. It checks the current cycle, drives the inputs
    // for the next rising edge, updates the model, and advances one cycle.
    task automatic cycle(input bit rv, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit rr);
        check_outputs();
        req_valid = rv;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        if (in_flight) begin
            if (cyc >= acc_cyc + 1 + LAT && rr) begin
                in_flight = 1'b0;
                void'(exp_q.pop_front());
                void'(expf_q.pop_front());
                n_rsp++;
            end
        end else if (rv) begin
            in_flight = 1'b1;
            acc_cyc   = cyc + 1;
            cur_a     = a;
            cur_b     = b;
            cur_op    = op;
            exp_q.push_back(fake_res(a, b, op));
            expf_q.push_back(fake_flags(a, b, op));
            n_req++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, '0, '0, 1'b1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state: every output is 0, including req_ready while reset is high.
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_req_ready", 32'(req_ready), 1);

        // MUL_SR 0x7C00 * 0x0000 with an immediate response accept.
        cycle(1'b1, 3'b101, 16'h7C00, 16'h0000, 1'b1);
        idle_cycles(LAT + 4);

        // Backpressure: rsp_ready held low while a new request waits.
        cycle(1'b1, 3'b100, 16'h3C00, 16'h4000, 1'b0);
        for (int i = 0; i < LAT + 2 + 5; i++) cycle(1'b1, 3'b010, 16'h1111, 16'h2222, 1'b0);
        cycle(1'b1, 3'b010, 16'h1111, 16'h2222, 1'b1);   // response handshake
        cycle(1'b1, 3'b010, 16'h1111, 16'h2222, 1'b1);   // new op accepted from IDLE
        idle_cycles(LAT + 4);

        // Reset pulse in the second EXEC cycle: the op is discarded.
        cycle(1'b1, 3'b110, 16'h5A5A, 16'hC3C3, 1'b0);
        cycle(1'b0, 3'd0, '0, '0, 1'b0);
        check_outputs();
        reset = 1'b1;
        #1;
        chk_all_zero("mid_exec_reset");
        in_flight = 1'b0;
        void'(exp_q.pop_back());
        void'(expf_q.pop_back());
        n_req--;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        #1;
        chk("reset_release_req_ready", 32'(req_ready), 1);
        idle_cycles(LAT + 3);

        // Random back-to-back traffic with random response backpressure.
        begin
            int start_rsp;
            start_rsp = n_rsp;
            for (int i = 0; i < 3000 && (n_rsp - start_rsp) < 25; i++) begin
                cycle(1'($urandom_range(0, 9) < 7), 3'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)));
            end
            chk("random_rsp_budget", 32'((n_rsp - start_rsp) >= 25), 1);
        end
        idle_cycles(LAT + 6);

        chk("rsp_count_matches_req", 32'(n_rsp), 32'(n_req));
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
